sdram_burst_reader: RTL and testbench

Read agent on the arbiter's reader port. Converts one transfer request (base address, number of bursts) into a stream of BURST_LEN-word SDRAM read commands. It captures the returned read data into an internal FIFO and presents it as a valid/ready stream, for example to a video line buffer. Command issue is credit-limited, so data returned by the controller, which cannot be back-pressured, never overflows the FIFO.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_rd_fifo.sv | 69 ++++++
 rtl/sdram_burst_reader.sv | 152 +++++++++++++++
 tb/tb_sdram_burst_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM agents.
package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } burst_reader_state_t;

    localparam int DEF_BURST_LEN = 8;
    localparam int BURST_SHIFT   = $clog2(DEF_BURST_LEN);

    function automatic int burst_shift(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/sdram_rd_fifo.sv
// Read-data FIFO with a registered output stage; a push into an empty FIFO
// bypasses the array so the word is visible on the next cycle.
module sdram_rd_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      mcount;
    logic             pop_ok;
    logic             push_ok;
    logic             can_load;
    logic             bypass;
    logic             mem_wr;
    logic             mem_rd;

    assign count    = mcount + (AW+1)'(rvalid);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_ok   = pop && rvalid;
    assign push_ok  = push && !full;
    assign can_load = !rvalid || pop_ok;
    assign bypass   = push_ok && (mcount == '0) && can_load;
    assign mem_wr   = push_ok && !bypass;
    assign mem_rd   = (mcount != '0) && can_load;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr   <= '0;
            rptr   <= '0;
            mcount <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (mem_wr) wptr <= wptr + AW'(1);
            if (mem_rd) rptr <= rptr + AW'(1);
            mcount <= mcount + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
            if (bypass) begin
                rvalid <= 1'b1;
                rdata  <= wdata;
            end else if (mem_rd) begin
                rvalid <= 1'b1;
                rdata  <= mem[rptr];
            end else if (pop_ok) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_reader.sv
// Turns one transfer request into credit-limited burst reads and streams the
// returned words out through a local FIFO.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing burst commands as FIFO credit allows
// DRAIN | all commands issued, waiting for data to flow out
// DONE  | one-cycle done pulse (zero-burst requests spend an extra cycle here)
module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_bursts,
    output logic                  busy,
    output logic                  done,
    output logic                  reader_valid,
    input  logic                  reader_ready,
    output logic [ADDR_WIDTH-1:0] reader_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  overflow_err
);

    localparam int SHIFT = burst_shift(BURST_LEN);
    localparam int TW    = CNT_WIDTH + SHIFT;
    localparam int OW    = $clog2(FIFO_DEPTH) + 1;

    burst_reader_state_t  state;
    logic [CNT_WIDTH-1:0] bursts_left;
    logic [TW-1:0]        total_words;
    logic [TW-1:0]        words_out;
    logic [TW-1:0]        words_out_nxt;
    logic [OW-1:0]        outstanding;
    logic [OW-1:0]        fifo_count;
    logic                 fifo_full;
    logic [OW:0]          reserved;
    logic                 credit_ok;
    logic                 cmd_hs;
    logic                 out_hs;
    logic                 rd_accept;
    logic                 rd_drop;
    logic                 finish_now;

    sdram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .push   (rd_accept),
        .wdata  (rd_data),
        .pop    (out_hs),
        .rvalid (out_valid),
        .rdata  (out_data),
        .count  (fifo_count),
        .full   (fifo_full)
    );

    // Credit counts words already buffered plus words still owed by the controller.
    assign reserved      = (OW+1)'(fifo_count) + (OW+1)'(outstanding) + (OW+1)'(BURST_LEN);
    assign credit_ok     = (reserved <= (OW+1)'(FIFO_DEPTH));
    assign cmd_hs        = reader_valid && reader_ready;
    assign out_hs        = out_valid && out_ready;
    assign rd_accept     = rd_valid && (outstanding != '0);
    assign rd_drop       = rd_valid && (outstanding == '0);
    assign words_out_nxt = words_out + TW'(out_hs);
    assign finish_now    = (outstanding == '0) && (words_out_nxt == total_words) &&
                           (fifo_count == OW'(out_hs));
    assign out_last      = out_valid && (words_out == total_words - TW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            bursts_left  <= '0;
            total_words  <= '0;
            words_out    <= '0;
            outstanding  <= '0;
            reader_valid <= 1'b0;
            reader_addr  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            outstanding <= outstanding + (cmd_hs ? OW'(BURST_LEN) : '0) - OW'(rd_accept);
            words_out   <= words_out_nxt;
            if (rd_drop || (rd_accept && fifo_full)) begin
                overflow_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        reader_addr <= base_addr;
                        bursts_left <= num_bursts;
                        total_words <= TW'(num_bursts) << SHIFT;
                        words_out   <= '0;
                        busy        <= 1'b1;
                        if (num_bursts == '0) begin
                            state <= DONE;
                        end else begin
                            state        <= ISSUE;
                            reader_valid <= credit_ok;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_hs) begin
                        reader_valid <= 1'b0;
                        reader_addr  <= reader_addr + ADDR_WIDTH'(BURST_LEN);
                        bursts_left  <= bursts_left - CNT_WIDTH'(1);
                        if (bursts_left == CNT_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end else if (!reader_valid) begin
                        reader_valid <= (bursts_left != '0) && credit_ok;
                    end
                end
                DRAIN: begin
                    if (finish_now) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench: commands and words are predicted at request time, a
// controller model returns data, and a monitor compares everything the DUT emits.
module tb_sdram_burst_reader;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 8;
    localparam int FD = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_bursts = '0;
    logic          busy;
    logic          done;
    logic          reader_valid;
    logic          reader_ready = 1'b0;
    logic [AW-1:0] reader_addr;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          overflow_err;

    sdram_burst_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .base_addr    (base_addr),
        .num_bursts   (num_bursts),
        .busy         (busy),
        .done         (done),
        .reader_valid (reader_valid),
        .reader_ready (reader_ready),
        .reader_addr  (reader_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } out_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [AW-1:0] exp_cmd[$];
    out_t          exp_out[$];
    logic [DW-1:0] ctrl_data[$];
    rd_t           pending[$];

    int n_checks = 0;
    int n_pass = 0;
    int n_cmds = 0;
    int last_due = 0;
    int last_hs_cyc = 0;
    int or_mode = 1;    // 0: hold low, 1: hold high, 2: random
    int rr_mode = 1;    // 0: driven by main sequence, 1: high, 2: random
    bit inject = 1'b0;
    bit exp_ovf = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Controller model plus ready generators, driven just after each rising edge.
    initial begin
        rd_t r;
        forever begin
            @(posedge clk);
            #1;
            if (or_mode == 0) out_ready = 1'b0;
            else if (or_mode == 1) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
            if (rr_mode == 1) reader_ready = 1'b1;
            else if (rr_mode == 2) reader_ready = ($urandom_range(0, 2) != 0);
            if (!rstn) begin
                rd_valid = 1'b0;
            end else if (inject) begin
                rd_valid = 1'b1;
                rd_data  = 16'hdead;
                inject   = 1'b0;
            end else if (pending.size() != 0 && pending[0].due <= cyc) begin
                r        = pending.pop_front();
                rd_valid = 1'b1;
                rd_data  = r.data;
            end else begin
                rd_valid = 1'b0;
            end
        end
    end

    // Monitor: compares command and output handshakes against the scoreboard.
    initial begin
        out_t          e;
        rd_t           r;
        bit            stall_prev;
        logic [DW-1:0] prev_data;
        stall_prev = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall_prev = 1'b0;
            end else begin
                if (reader_valid && reader_ready) begin
                    n_cmds++;
                    if (exp_cmd.size() == 0) check("cmd_extra", 32'(reader_addr), 32'hffffffff);
                    else check("cmd_addr", 32'(reader_addr), 32'(exp_cmd.pop_front()));
                    for (int i = 0; i < BL; i++) begin
                        if (ctrl_data.size() != 0) begin
                            r.data = ctrl_data.pop_front();
                            r.due  = cyc + 4;
                            if (r.due <= last_due) r.due = last_due + 1;
                            last_due = r.due;
                            pending.push_back(r);
                        end
                    end
                end
                if (stall_prev) begin
                    check("out_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, prev_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        check("out_extra", 32'(out_data), 32'hffffffff);
                    end else begin
                        e = exp_out.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                        if (e.last) last_hs_cyc = cyc;
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    task automatic start_xfer(input logic [AW-1:0] base, input int n, input bit seq, output int s_cyc);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        out_t          o;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i * BL);
            exp_cmd.push_back(a);
        end
        for (int w = 0; w < n * BL; w++) begin
            d = seq ? DW'(w) : DW'($urandom);
            ctrl_data.push_back(d);
            o.data = d;
            o.last = (w == n * BL - 1);
            exp_out.push_back(o);
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = base;
        num_bursts = CW'(n);
        s_cyc      = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int d_cyc);
        bit seen;
        seen  = 1'b0;
        d_cyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen  = 1'b1;
                d_cyc = cyc;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_end(input string name);
        check({name, "_cmds_left"}, 32'(exp_cmd.size()), 32'd0);
        check({name, "_words_left"}, 32'(exp_out.size()), 32'd0);
        check({name, "_ovf"}, 32'(overflow_err), 32'(exp_ovf));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_rvalid"}, 32'(reader_valid), 32'd0);
        check({name, "_raddr"}, 32'(reader_addr), 32'd0);
        check({name, "_ovalid"}, 32'(out_valid), 32'd0);
        check({name, "_odata"}, 32'(out_data), 32'd0);
        check({name, "_olast"}, 32'(out_last), 32'd0);
        check({name, "_ovf"}, 32'(overflow_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, c;
        bit seen;
        logic [AW-1:0] rb;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        // Single burst with a known data pattern.
        or_mode = 1;
        rr_mode = 1;
        start_xfer(24'h000100, 1, 1'b1, s);
        @(negedge clk);
        check("t1_first_cmd", 32'(reader_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 200, d);
        check("t1_done_lat", 32'(d), 32'(last_hs_cyc + 1));
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check_end("t1");

        // Address wrap, random handshakes, and an ignored start mid-transfer.
        or_mode = 2;
        rr_mode = 2;
        start_xfer(24'hFFFFF8, 3, 1'b0, s);
        repeat (6) @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = 24'h123456;
        num_bursts = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t2_busy_after_start", 32'(busy), 32'd1);
        wait_done("t2", 500, d);
        check_end("t2");

        // Credit limit with a stalled sink.
        or_mode = 0;
        rr_mode = 1;
        c = n_cmds;
        start_xfer(24'h004000, 16, 1'b0, s);
        repeat (150) @(negedge clk);
        check("t3_cmds_held", 32'(n_cmds - c), 32'd8);
        check("t3_rvalid_low", 32'(reader_valid), 32'd0);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_no_ovf", 32'(overflow_err), 32'd0);
        or_mode = 2;
        wait_done("t3", 3000, d);
        check_end("t3");

        // Command held while the arbiter stalls.
        or_mode = 1;
        rr_mode = 0;
        reader_ready = 1'b0;
        start_xfer(24'h000200, 2, 1'b0, s);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = reader_valid;
        end
        check("t4_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(reader_valid), 32'd1);
            check("t4_hold_addr", 32'(reader_addr), 32'h000200);
        end
        c = n_cmds;
        @(posedge clk);
        #1;
        reader_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_accept", 32'(n_cmds - c), 32'd1);
        rr_mode = 1;
        wait_done("t4", 300, d);
        check_end("t4");

        // Zero-length request.
        c = n_cmds;
        start_xfer(24'h000300, 0, 1'b0, s);
        wait_done("t5", 10, d);
        check("t5_done_lat", 32'(d), 32'(s + 2));
        check("t5_no_cmd", 32'(n_cmds - c), 32'd0);
        check_end("t5");

        // Randomized transfers.
        or_mode = 2;
        rr_mode = 2;
        for (int k = 0; k < 4; k++) begin
            rb = AW'($urandom);
            start_xfer(rb, $urandom_range(1, 5), 1'b0, s);
            wait_done("rnd", 1000, d);
            check_end("rnd");
        end

        // Stray read data while idle sets the sticky error.
        @(posedge clk);
        #1;
        inject = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_stray_ovf", 32'(overflow_err), 32'd1);
        exp_ovf = 1'b1;
        start_xfer(24'h000500, 2, 1'b0, s);
        wait_done("t6a", 500, d);
        check_end("t6a");

        // Asynchronous reset in the middle of a transfer.
        start_xfer(24'h000600, 4, 1'b0, s);
        repeat (12) @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("t6_rst");
        exp_cmd.delete();
        exp_out.delete();
        ctrl_data.delete();
        pending.delete();
        last_due = 0;
        exp_ovf  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        start_xfer(24'h000700, 1, 1'b0, s);
        wait_done("t6b", 300, d);
        check_end("t6b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
